spi_flash_ctrl: RTL and testbench
=================================

Name: spi_flash_ctrl

Overview:
Hardware sequencer for the board's SPI configuration flash (SCK/MOSI/MISO/CS), replacing CPU bit-banging through the misc.out port. It provides two modes: single raw byte exchanges, and an autonomous READ (0x03) burst that pushes received bytes into a small RX FIFO. It sits on the j1 IO bus behind the top-level registered IO strobes. The top level decodes one IO address bit into sel and drives reg_addr from two lower address bits.

Parameters:
DIV, 0, SCK half-period minus one in clk cycles; SCK frequency = clk/(2*(DIV+1)).
FIFO_DEPTH, 4, RX FIFO entries (power of two, at least 2).
CS_GAP, 2, minimum clk cycles cs_n stays high between transactions.

Ports:
clk  in  1  system clock
resetq  in  1  asynchronous active-low reset
sel  in  1  block selected by IO address decode
reg_wr  in  1  registered IO write strobe (one cycle)
reg_rd  in  1  registered IO read strobe (one cycle)
reg_addr  in  2  register select
wdata  in  16  write data
rdata  out  16  read data; combinational from reg_addr and state
flash_sck  out  1  SPI clock, mode 0, idles low
flash_mosi  out  1  SPI data out
flash_miso  in  1  SPI data in (already synchronised by the input pin cell)
flash_cs_n  out  1  flash chip select, active low

Behaviour:
- Reset values: flash_sck=0, flash_mosi=0, flash_cs_n=1. FSM in IDLE, FIFO empty, addr=0, raw_rx=0, count=0, cs_hold=0.
- Register map. Writes take effect only when sel&reg_wr; reads have side effects only when sel&reg_rd.
  - addr 0, write: start a raw byte exchange of wdata[7:0].
  - addr 0, read: {8'h00, FIFO head}. Pops the FIFO if non-empty. Empty FIFO returns 0 and nothing changes.
  - addr 1, write: bit0 = cs_hold; bit1 = start burst; bits[15:8] = burst length (0 means 256).
  - addr 1, read: status {12'b0, cs_active, fifo_full, fifo_nonempty, busy}.
  - addr 2, write: addr[15:0]. Read: {8'h00, raw_rx}.
  - addr 3, write: addr[23:16] = wdata[7:0]. Read: {7'b0, remaining burst bytes[8:0]}.
- FSM states: IDLE, CMD, ADR, DAT, RAW, GAP.
  - IDLE + raw write: go to RAW, cs_n=0.
  - IDLE + start burst: go to CMD, cs_n=0.
  - CMD shifts 8'h03, MSB first, then goes to ADR.
  - ADR shifts 24 address bits, MSB first, then goes to DAT.
  - DAT shifts N bytes, then goes to GAP.
  - RAW shifts one byte. Afterwards: GAP if cs_hold=0; IDLE with cs_n still low if cs_hold=1.
  - GAP holds cs_n=1 for CS_GAP cycles, then goes to IDLE.
- Bit timing (mode 0):
  - MOSI is set up at least one half-period before the SCK rising edge.
  - MISO is sampled on the clk cycle where SCK rises.
  - MOSI updates on the SCK falling edge.
  - A byte takes 16*(DIV+1) clk cycles.
  - The first SCK rise occurs DIV+1 cycles after cs_n falls.
- busy=1 in every state except IDLE. It asserts the cycle after the accepted strobe.
- Raw exchange: raw_rx updates when the 8th bit is sampled. Raw bytes never enter the FIFO.
- Burst data: each completed byte is pushed into the FIFO and decrements count.
  - Before starting each byte, if the FIFO is full, SCK is held low and the FSM stalls until a pop. The flash tolerates a stopped clock.
  - After the last byte, addr is left incremented by N (24-bit wrap past FFFFFF to 000000), so a back-to-back burst continues sequentially.
- Simultaneous events:
  - A pop and a push in the same cycle leave the count unchanged, including when the FIFO is full.
  - Raw or start writes while busy are ignored. Address and ctrl writes while busy are ignored.
  - A start write with cs_hold=1 while cs_active but idle is accepted. The burst reuses the asserted CS.
- Reset mid-transfer: an immediate asynchronous return to the reset values above. No partial byte is pushed.

Decomposition:
- Shared package spi_flash_pkg holds:
  - register index constants (REG_DATA=0, REG_CTRL=1, REG_ADDR_LO=2, REG_ADDR_HI=3);
  - the status bit positions;
  - the CMD_READ=8'h03 constant;
  - the FSM state enum.
- One natural sub-module: spi_rx_fifo (synchronous FIFO with FIFO_DEPTH entries of 8 bits, with push, pop, full and empty). Everything else lives in spi_flash_ctrl.

Test Plan:
- Raw exchange: DIV=0, write 8'h9F to reg 0 with cs_hold=1, flash model returns 8'hEF. Required: busy for 16 cycles; MOSI bits 1,0,0,1,1,1,1,1; raw_rx=8'hEF; cs_n stays low. Then write ctrl with cs_hold=0 and perform a raw 8'h00 exchange; cs_n rises after the byte and stays high for 2 cycles.
- Burst of 3: addr=24'h012345, length=3, model memory at 012345.. = A1 B2 C3. Required:
  - MOSI stream is 03 01 23 45;
  - FIFO reads give A1, B2, C3, then 0;
  - addr ends at 012348.
- FIFO-full stall: burst length 6 with no reads. Required: SCK stays low after 4 bytes with status fifo_full=1 and busy=1. Each pop releases exactly one more byte; all 6 bytes arrive in order.
- Collisions: write 8'h55 to reg 0 mid-burst. Required: ignored, and the burst data is unchanged. A pop coinciding with a push while full leaves fifo_full=1 and loses no data.
- Wrap and 256: addr=24'hFFFFFF, length field 0. Required: 256 bytes transferred, count reaches 0, addr=24'h0000FF.
- Reset: assert resetq low during ADR. Required: on the same edge cs_n=1, sck=0 and busy=0; after release, status reads 0.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants and FSM state type for the SPI flash sequencer
package spi_flash_pkg;
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_ADDR_LO = 2'd2;
  localparam logic [1:0] REG_ADDR_HI = 2'd3;
  localparam int ST_BUSY     = 0;
  localparam int ST_NONEMPTY = 1;
  localparam int ST_FULL     = 2;
  localparam int ST_CS       = 3;
  localparam logic [7:0] CMD_READ = 8'h03;
  typedef enum logic [2:0] {IDLE, CMD, ADR, DAT, RAW, GAP} state_t;
endpackage

// File: rtl/spi_flash_if.sv
// spi_flash_if: j1 IO bus register port of the SPI flash sequencer
interface spi_flash_if;
  logic        sel;
  logic        reg_wr;
  logic        reg_rd;
  logic [1:0]  reg_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  modport master(output sel, reg_wr, reg_rd, reg_addr, wdata, input rdata);
  modport slave(input sel, reg_wr, reg_rd, reg_addr, wdata, output rdata);
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: small synchronous byte FIFO for burst read data
module spi_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = wp == (rp ^ {1'b1, {AW{1'b0}}});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp[AW-1:0]];
  // read/write pointers; the extra MSB tells full from empty
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  // storage needs no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: SPI flash sequencer with raw byte exchange and READ burst into an RX FIFO
module spi_flash_ctrl #(
  parameter int DIV        = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 2
) (
  input  logic     clk,
  input  logic     resetq,
  spi_flash_if.slave bus,
  output logic     flash_sck,
  output logic     flash_mosi,
  input  logic     flash_miso,
  output logic     flash_cs_n
);
  import spi_flash_pkg::*;
  state_t state, state_d;
  logic [15:0] dcnt;
  logic [2:0] bcnt;
  logic [1:0] acnt;
  logic [7:0] gcnt, txs, raw_rx, nxt_tx, start_tx, head, rx_byte;
  logic [6:0] rxs;
  logic [8:0] count;
  logic [23:0] addr;
  logic [3:0] st;
  logic cs_hold, wr, rd, idle, raw_go, ctrl_wr, burst_go, shifting, stall;
  logic tick, rise, fall, byte_end, push, pop, full, empty;
  assign wr       = bus.sel & bus.reg_wr;
  assign rd       = bus.sel & bus.reg_rd;
  assign idle     = state == IDLE;
  assign raw_go   = idle && wr && bus.reg_addr == REG_DATA;
  assign ctrl_wr  = idle && wr && bus.reg_addr == REG_CTRL;
  assign burst_go = ctrl_wr && bus.wdata[1];
  assign start_tx = raw_go ? bus.wdata[7:0] : CMD_READ;
  assign shifting = state inside {CMD, ADR, DAT, RAW};
  assign stall    = state == DAT && bcnt == 3'd0 && !flash_sck && full;
  assign tick     = shifting && !stall && dcnt == 16'(DIV);
  assign rise     = tick && !flash_sck;
  assign fall     = tick && flash_sck;
  assign byte_end = fall && bcnt == 3'd7;
  assign rx_byte  = {rxs, flash_miso};
  assign push     = rise && bcnt == 3'd7 && state == DAT;
  assign pop      = rd && bus.reg_addr == REG_DATA && !empty;
  spi_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .resetq(resetq), .push(push), .pop(pop), .din(rx_byte),
    .dout(head), .full(full), .empty(empty)
  );
  // status word assembled by bit position
  always_comb begin
    st = '0;
    st[ST_BUSY]     = !idle;
    st[ST_NONEMPTY] = !empty;
    st[ST_FULL]     = full;
    st[ST_CS]       = !flash_cs_n;
  end
  assign bus.rdata = bus.reg_addr == REG_DATA ? {8'h00, empty ? 8'h00 : head} :
                     bus.reg_addr == REG_CTRL ? {12'h000, st} :
                     bus.reg_addr == REG_ADDR_LO ? {8'h00, raw_rx} : {7'h00, count};
  // state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= IDLE;
    else state <= state_d;
  end
  // next state and the byte to shift after the current one ends
  always_comb begin
    state_d = state;
    nxt_tx  = 8'h00;
    unique case (state)
      IDLE: state_d = raw_go ? RAW : burst_go ? CMD : IDLE;
      CMD: begin
        nxt_tx  = addr[23:16];
        state_d = byte_end ? ADR : CMD;
      end
      ADR: begin
        nxt_tx  = acnt == 2'd0 ? addr[15:8] : acnt == 2'd1 ? addr[7:0] : 8'h00;
        state_d = byte_end && acnt == 2'd2 ? DAT : ADR;
      end
      DAT: state_d = byte_end && count == 9'd0 ? GAP : DAT;
      RAW: state_d = byte_end ? (cs_hold ? IDLE : GAP) : RAW;
      GAP: state_d = gcnt == 8'd0 ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // SPI bit engine, register writes, burst bookkeeping
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      flash_sck  <= 1'b0;
      flash_mosi <= 1'b0;
      flash_cs_n <= 1'b1;
      dcnt       <= '0;
      bcnt       <= '0;
      acnt       <= '0;
      gcnt       <= '0;
      txs        <= '0;
      rxs        <= '0;
      raw_rx     <= '0;
      count      <= '0;
      addr       <= '0;
      cs_hold    <= 1'b0;
    end else begin
      if (raw_go || burst_go) begin
        flash_cs_n <= 1'b0;
        dcnt       <= '0;
        bcnt       <= '0;
        acnt       <= '0;
        flash_mosi <= start_tx[7];
        txs        <= {start_tx[6:0], 1'b0};
      end
      if (ctrl_wr) cs_hold <= bus.wdata[0];
      if (burst_go) count <= bus.wdata[15:8] == 8'd0 ? 9'd256 : {1'b0, bus.wdata[15:8]};
      if (idle && wr && bus.reg_addr == REG_ADDR_LO) addr[15:0] <= bus.wdata;
      if (idle && wr && bus.reg_addr == REG_ADDR_HI) addr[23:16] <= bus.wdata[7:0];
      if (shifting) dcnt <= (tick || stall) ? 16'd0 : dcnt + 16'd1;
      if (tick) flash_sck <= ~flash_sck;
      if (rise) rxs <= rx_byte[6:0];
      if (rise && bcnt == 3'd7 && state == RAW) raw_rx <= rx_byte;
      if (fall) begin
        bcnt       <= bcnt + 3'd1;
        flash_mosi <= bcnt == 3'd7 ? nxt_tx[7] : txs[7];
        txs        <= bcnt == 3'd7 ? {nxt_tx[6:0], 1'b0} : {txs[6:0], 1'b0};
      end
      if (byte_end && state == ADR) acnt <= acnt + 2'd1;
      if (push) begin
        count <= count - 9'd1;
        addr  <= addr + 24'd1;
      end
      if (state_d == GAP && state != GAP) begin
        flash_cs_n <= 1'b1;
        gcnt       <= 8'(CS_GAP - 1);
      end else if (state == GAP) gcnt <= gcnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed bench with a behavioural SPI flash model
module tb_spi_flash_ctrl;
  logic clk = 1'b0, resetq, flash_miso = 1'b0;
  logic flash_sck, flash_mosi, flash_cs_n;
  int checks = 0, failures = 0;
  int n, hi, got, errs, nz, cyc;
  logic [15:0] s, d;
  logic [7:0] ex;
  logic f_push = 1'b0, f_pop = 1'b0, f_full, f_empty;
  logic [7:0] f_din = 8'h00, f_dout;
  logic [31:0] sh = '0;
  int bi = 0;
  logic [23:0] cap = '0;
  logic [7:0] raw_resp = 8'h00, mb;
  logic model_raw = 1'b0, psck = 1'b0, pcs = 1'b1;
  logic [7:0] mosi_q[$];

  spi_flash_if bus();
  spi_flash_ctrl #(.DIV(0), .FIFO_DEPTH(4), .CS_GAP(2)) dut (
    .clk(clk), .resetq(resetq), .bus(bus), .flash_sck(flash_sck),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso), .flash_cs_n(flash_cs_n)
  );
  spi_rx_fifo #(.FIFO_DEPTH(4)) uf (
    .clk(clk), .resetq(resetq), .push(f_push), .pop(f_pop), .din(f_din),
    .dout(f_dout), .full(f_full), .empty(f_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_at(input logic [23:0] a);
    return a == 24'h012345 ? 8'hA1 : a == 24'h012346 ? 8'hB2 :
           a == 24'h012347 ? 8'hC3 : a[7:0] ^ 8'h5A;
  endfunction

  // flash model: captures MOSI on SCK rise, drives MISO on SCK fall (mode 0)
  always @(flash_sck or flash_cs_n) begin
    if (flash_cs_n === 1'b1) begin
      bi = 0;
      flash_miso = 1'b0;
    end else if (pcs === 1'b1) begin
      flash_miso = model_raw ? raw_resp[7] : 1'b0;
    end else if (flash_sck && !psck) begin
      sh = {sh[30:0], flash_mosi};
      bi++;
      if (bi % 8 == 0) mosi_q.push_back(sh[7:0]);
      if (bi == 32) cap = sh[23:0];
    end else if (!flash_sck && psck) begin
      mb = bi >= 32 ? mem_at(cap + 24'((bi - 32) / 8)) : 8'h00;
      flash_miso = model_raw ? raw_resp[7 - (bi % 8)] : mb[7 - (bi % 8)];
    end
    psck = flash_sck;
    pcs = flash_cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] v);
    @(negedge clk);
    bus.sel = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = a; bus.wdata = v;
    @(negedge clk);
    bus.sel = 1'b0; bus.reg_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk);
    bus.sel = 1'b1; bus.reg_rd = 1'b1; bus.reg_addr = a;
    #1 v = bus.rdata;
    @(negedge clk);
    bus.sel = 1'b0; bus.reg_rd = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [15:0] v);
    bus.reg_addr = a;
    #1 v = bus.rdata;
  endtask

  task automatic wait_idle(output int cnt, output int cs_hi);
    logic [15:0] st;
    cnt = 0; cs_hi = 0;
    peek(2'd1, st);
    while (st[0] && cnt < 10000) begin
      if (flash_cs_n) cs_hi++;
      cnt++;
      @(negedge clk);
      peek(2'd1, st);
    end
    chk("idle_timeout", {31'd0, cnt >= 10000}, 32'd0);
  endtask

  initial begin
    bus.sel = 1'b0; bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.reg_addr = 2'd0; bus.wdata = 16'h0;
    resetq = 1'b1;
    #1 resetq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", flash_cs_n, 1);
    chk("rst_sck", flash_sck, 0);
    chk("rst_mosi", flash_mosi, 0);
    resetq = 1'b1;
    @(negedge clk);
    peek(2'd1, s); chk("rst_status", s, 16'h0000);
    peek(2'd3, s); chk("rst_count", s, 16'h0000);
    rd_reg(2'd0, d); chk("rst_empty_read", d, 16'h0000);

    // raw exchange with cs_hold
    model_raw = 1'b1; raw_resp = 8'hEF; mosi_q.delete();
    wr_reg(2'd1, 16'h0001);
    wr_reg(2'd0, 16'h009F);
    wait_idle(n, hi);
    chk("raw_busy_cycles", n, 16);
    chk("raw_mosi", {24'(mosi_q.size()), mosi_q[0]}, {24'd1, 8'h9F});
    peek(2'd2, s); chk("raw_rx", s, 16'h00EF);
    repeat (5) @(negedge clk);
    chk("raw_cs_held", flash_cs_n, 0);
    peek(2'd1, s); chk("raw_hold_status", s, 16'h0008);

    // raw exchange without hold: cs_n rises for the gap
    wr_reg(2'd1, 16'h0000);
    mosi_q.delete();
    wr_reg(2'd0, 16'h0000);
    wait_idle(n, hi);
    chk("raw2_busy_cycles", n, 18);
    chk("raw2_cs_gap", hi, 2);
    chk("raw2_cs_n", flash_cs_n, 1);
    chk("raw2_mosi", {24'(mosi_q.size()), mosi_q[0]}, {24'd1, 8'h00});
    peek(2'd1, s); chk("raw2_no_fifo", s, 16'h0000);

    // burst of 3
    model_raw = 1'b0;
    wr_reg(2'd2, 16'h2345);
    wr_reg(2'd3, 16'h0001);
    mosi_q.delete();
    wr_reg(2'd1, 16'h0302);
    wait_idle(n, hi);
    chk("burst3_cycles", n, 114);
    chk("burst3_hdr", {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]}, 32'h03012345);
    rd_reg(2'd0, d); chk("burst3_b0", d, 16'h00A1);
    rd_reg(2'd0, d); chk("burst3_b1", d, 16'h00B2);
    rd_reg(2'd0, d); chk("burst3_b2", d, 16'h00C3);
    rd_reg(2'd0, d); chk("burst3_empty", d, 16'h0000);
    peek(2'd3, s); chk("burst3_count", s, 16'h0000);

    // burst of 6 with no reads: stall on a full FIFO
    mosi_q.delete();
    wr_reg(2'd1, 16'h0602);
    n = 0;
    peek(2'd1, s);
    while (!s[2] && n < 2000) begin
      @(negedge clk);
      peek(2'd1, s);
      n++;
    end
    chk("stall_reached", {31'd0, s[2]}, 32'd1);
    repeat (40) @(negedge clk);
    chk("stall_sck", flash_sck, 0);
    peek(2'd1, s); chk("stall_status", s, 16'h000F);
    chk("stall_bytes4", mosi_q.size(), 8);
    chk("stall_hdr", {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]}, 32'h03012348);
    wr_reg(2'd0, 16'h0055);
    wr_reg(2'd2, 16'h0000);
    rd_reg(2'd0, d); chk("stall_pop1", d, 16'h0012);
    repeat (40) @(negedge clk);
    chk("stall_bytes5", mosi_q.size(), 9);
    peek(2'd1, s); chk("stall_status5", s, 16'h000F);
    rd_reg(2'd0, d); chk("stall_pop2", d, 16'h0013);
    repeat (40) @(negedge clk);
    chk("stall_bytes6", mosi_q.size(), 10);
    peek(2'd1, s); chk("stall_done_status", s, 16'h0006);
    rd_reg(2'd0, d); chk("stall_pop3", d, 16'h0010);
    rd_reg(2'd0, d); chk("stall_pop4", d, 16'h0011);
    rd_reg(2'd0, d); chk("stall_pop5", d, 16'h0016);
    rd_reg(2'd0, d); chk("stall_pop6", d, 16'h0017);
    rd_reg(2'd0, d); chk("stall_empty", d, 16'h0000);
    nz = 0;
    for (int i = 4; i < 10; i++) if (mosi_q[i] != 8'h00) nz++;
    chk("collide_mosi_clean", nz, 0);

    // sequential continuation; the address write during busy was dropped
    mosi_q.delete();
    wr_reg(2'd1, 16'h0102);
    wait_idle(n, hi);
    chk("cont_hdr", {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]}, 32'h0301234E);
    rd_reg(2'd0, d); chk("cont_data", d, 16'h0014);

    // FIFO pop and push in one cycle while full
    @(negedge clk);
    f_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_din = 8'(17 * (i + 1));
      @(negedge clk);
    end
    chk("fifo_full", f_full, 1);
    f_din = 8'h55; f_pop = 1'b1;
    chk("fifo_head_before", f_dout, 8'h11);
    @(negedge clk);
    f_push = 1'b0; f_pop = 1'b0;
    chk("fifo_full_after_pushpop", f_full, 1);
    f_pop = 1'b1;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (f_dout !== 8'(17 * (i + 2))) errs++;
      @(negedge clk);
    end
    f_pop = 1'b0;
    chk("fifo_order", errs, 0);
    chk("fifo_empty", f_empty, 1);

    // 256-byte burst wrapping the 24-bit address
    wr_reg(2'd2, 16'hFFFF);
    wr_reg(2'd3, 16'h00FF);
    mosi_q.delete();
    wr_reg(2'd1, 16'h0002);
    got = 0; errs = 0; cyc = 0;
    while (got < 256 && cyc < 20000) begin
      peek(2'd1, s);
      if (s[1]) begin
        rd_reg(2'd0, d);
        ex = mem_at(24'hFFFFFF + 24'(got));
        if (d !== {8'h00, ex}) errs++;
        got++;
      end else @(negedge clk);
      cyc++;
    end
    wait_idle(n, hi);
    chk("wrap_count", got, 256);
    chk("wrap_data", errs, 0);
    chk("wrap_hdr", {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]}, 32'h03FFFFFF);
    peek(2'd3, s); chk("wrap_remaining", s, 16'h0000);
    mosi_q.delete();
    wr_reg(2'd1, 16'h0102);
    wait_idle(n, hi);
    chk("wrap_next_hdr", {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]}, 32'h030000FF);
    rd_reg(2'd0, d); chk("wrap_next_data", d, 16'h00A5);

    // reset asserted during the address phase
    wr_reg(2'd1, 16'h0102);
    repeat (20) @(negedge clk);
    chk("rst_mid_pre_cs", flash_cs_n, 0);
    #2 resetq = 1'b0;
    #1;
    chk("rst_mid_cs_n", flash_cs_n, 1);
    chk("rst_mid_sck", flash_sck, 0);
    peek(2'd1, s); chk("rst_mid_status", s, 16'h0000);
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    peek(2'd1, s); chk("rst_after_status", s, 16'h0000);
    peek(2'd3, s); chk("rst_after_count", s, 16'h0000);
    peek(2'd2, s); chk("rst_after_raw_rx", s, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
